// File: rtl/display_pkg.sv
// Shared constants, FSM state type and the leading-zero blank-mask helper
// for the BCD seven-segment display driver.
package display_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [31:0] BCD_MAX = 32'd99_999_999;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // A digit is blanked while everything above it is a leading zero; the
  // decimal-point digit ends the leading run so lower zeros stay visible.
  function automatic logic [NUM_DIGITS-1:0] blank_mask_f(
    input logic [4*NUM_DIGITS-1:0] digits,
    input logic                    blank_lz,
    input logic [3:0]              dp_pos
  );
    logic                  lead;
    logic [NUM_DIGITS-1:0] mask;
    lead = blank_lz;
    mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead    = lead && (digits[4*i +: 4] == 4'd0) && (dp_pos != 4'(i));
      mask[i] = lead;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment decoder.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Sequential double-dabble binary-to-BCD converter feeding an eight-digit
// display buffer, with registered cathode drive for the selected digit.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int BIN_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  input  logic             blank_lz,
  input  logic [3:0]       dp_pos,
  input  logic [2:0]       current_digit,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       segments,
  output logic             dp,
  output state_e           dbg_state_o
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  // Handshake: value_valid is a single-cycle strobe accepted only while busy
  // is low; a strobe seen while busy is dropped, never queued.
  state_e                  state_q, state_d;
  logic [BIN_W-1:0]        value_q, value_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [4*NUM_DIGITS-1:0] adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    blz_q, blz_d;
  logic [3:0]              dpl_q, dpl_d;
  logic [4*NUM_DIGITS-1:0] buf_q, buf_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [3:0]              dp_pos_q, dp_pos_d;
  logic                    ovf_q, ovf_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [3:0]              sel_nib;
  logic [6:0]              dec_seg;

  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    blz_d    = blz_q;
    dpl_d    = dpl_q;
    buf_d    = buf_q;
    mask_d   = mask_q;
    dp_pos_d = dp_pos_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (value_valid) begin
          value_d = value;
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          blz_d   = blank_lz;
          dpl_d   = dp_pos;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {adj[4*NUM_DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        if (32'(value_q) > BCD_MAX) begin
          buf_d = {NUM_DIGITS{4'd9}};
          ovf_d = 1'b1;
        end else begin
          buf_d = bcd_q;
          ovf_d = 1'b0;
        end
        mask_d   = blank_mask_f(buf_d, blz_q, dpl_q);
        dp_pos_d = dpl_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_nib = buf_q[{current_digit, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd_i (sel_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = mask_q[current_digit] ? SEG_BLANK : dec_seg;
    dp_d  = ({1'b0, current_digit} == dp_pos_q) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      value_q  <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      blz_q    <= 1'b0;
      dpl_q    <= 4'd8;
      buf_q    <= '0;
      mask_q   <= 8'b1111_1110;
      dp_pos_q <= 4'd8;
      ovf_q    <= 1'b0;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      blz_q    <= blz_d;
      dpl_q    <= dpl_d;
      buf_q    <= buf_d;
      mask_q   <= mask_d;
      dp_pos_q <= dp_pos_d;
      ovf_q    <= ovf_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign overflow    = ovf_q;
  assign segments    = seg_q;
  assign dp          = dp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver: decimal-arithmetic display model
// checked every cycle, plus hand-computed digit sweeps.
module tb_bcd_display_driver;

  localparam int BIN_W = 27;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BIN_W-1:0]  value;
  logic              value_valid;
  logic              blank_lz;
  logic [3:0]        dp_pos;
  logic [2:0]        current_digit;
  logic              busy;
  logic              overflow;
  logic [6:0]        segments;
  logic              dp;
  display_pkg::state_e dbg_state;

  int checks = 0;
  int errors = 0;

  bcd_display_driver #(.BIN_W(BIN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .value         (value),
    .value_valid   (value_valid),
    .blank_lz      (blank_lz),
    .dp_pos        (dp_pos),
    .current_digit (current_digit),
    .busy          (busy),
    .overflow      (overflow),
    .segments      (segments),
    .dp            (dp),
    .dbg_state_o   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: display contents as decimal digits
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  int   m_digits [8];
  bit   m_mask [8];
  int   m_dp;
  bit   m_ovf;
  bit   m_busy;
  int   m_cnt;
  int   p_val;
  bit   p_blz;
  int   p_dp;
  logic [6:0] exp_seg;
  logic       exp_dp;
  bit   m_valid = 0;

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_digits[i] = 0;
      m_mask[i]   = (i != 0);
    end
    m_dp  = 8;
    m_ovf = 0;
  endfunction

  function automatic void m_commit(input int v, input bit blz, input int dpp);
    int p;
    int top;
    p   = 1;
    top = 0;
    m_ovf = (v > 99_999_999);
    for (int i = 0; i < 8; i++) begin
      m_digits[i] = m_ovf ? 9 : (v / p) % 10;
      p = p * 10;
      if (m_digits[i] != 0) top = i;
    end
    if (dpp < 8 && dpp > top) top = dpp;
    for (int i = 0; i < 8; i++) m_mask[i] = blz && (i > top);
    m_dp = dpp;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_reset();
      m_busy  = 0;
      m_cnt   = 0;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_seg = m_mask[current_digit] ? 7'h7F : seg_tab[m_digits[current_digit]];
      exp_dp  = (int'(current_digit) == m_dp) ? 1'b0 : 1'b1;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == BIN_W + 1) begin
          m_commit(p_val, p_blz, p_dp);
          m_busy = 0;
        end
      end else if (value_valid) begin
        p_val  = int'(value);
        p_blz  = blank_lz;
        p_dp   = int'(dp_pos);
        m_busy = 1;
        m_cnt  = 0;
      end
    end
    m_valid = 1;
  end

  // Scoreboard compare every cycle
  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
      chk("cyc_segments", 32'(segments), 32'(exp_seg));
      chk("cyc_dp", 32'(dp), 32'(exp_dp));
    end
  end

  // Driver tasks
  task automatic pulse_load(input int v, input bit blz, input int dpp);
    value       = BIN_W'(v);
    blank_lz    = blz;
    dp_pos      = 4'(dpp);
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm, output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 100) chk({nm, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic load_measure(input string nm, input int v, input bit blz, input int dpp);
    int n;
    @(negedge clk);
    pulse_load(v, blz, dpp);
    wait_idle(nm, n);
    chk({nm, "_busy_len"}, 32'(n), 32'd28);
  endtask

  task automatic sweep(input string nm, input logic [55:0] exp_segs, input logic [7:0] exp_dps);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      current_digit = 3'(i);
      @(negedge clk);
      chk($sformatf("%s_seg%0d", nm, i), 32'(segments), 32'(exp_segs[7*i +: 7]));
      chk($sformatf("%s_dp%0d", nm, i), 32'(dp), 32'(exp_dps[i]));
    end
  endtask

  task automatic sweep_model();
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      current_digit = 3'(i);
    end
    @(negedge clk);
  endtask

  int extra_vals [6] = '{0, 99_999_999, 10_203, 134_217_727, 1_000, 60};
  int extra_dps  [6] = '{8, 0, 6, 2, 15, 1};

  initial begin
    int falls;
    int n;
    logic prev_busy;
    rst_n         = 1'b0;
    value         = '0;
    value_valid   = 1'b0;
    blank_lz      = 1'b0;
    dp_pos        = 4'd8;
    current_digit = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_seg0", 32'(segments), 32'(7'b1000000));
    chk("reset_dp", 32'(dp), 32'd1);

    // Full-width value
    load_measure("full", 12_345_678, 1'b0, 8);
    sweep("full", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                   7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 8'hFF);

    // Leading-zero blanking
    load_measure("lz42", 42, 1'b1, 8);
    sweep("lz42", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                   7'b0011001, 7'b0100100}, 8'hFF);

    // Decimal point protects zero digits below it
    load_measure("dp5", 5, 1'b1, 3);
    sweep("dp5", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000, 7'b1000000,
                  7'b1000000, 7'b0010010}, 8'b1111_0111);

    // Overflow saturation, then clear
    load_measure("ovf", 100_000_000, 1'b0, 8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    sweep("ovf", {8{7'b0010000}}, 8'hFF);
    load_measure("seven", 7, 1'b0, 8);
    chk("seven_ovf_clear", 32'(overflow), 32'd0);
    sweep("seven", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000,
                    7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, 8'hFF);

    // Load while busy is ignored
    @(negedge clk);
    pulse_load(123, 1'b1, 8);
    falls     = 0;
    prev_busy = busy;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin
        value       = BIN_W'(999);
        value_valid = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
      @(negedge clk);
      if (prev_busy === 1'b1 && busy === 1'b0) falls++;
      prev_busy = busy;
    end
    chk("lwb_falls", 32'(falls), 32'd1);
    sweep("lwb", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                  7'b1111001, 7'b0100100, 7'b0110000}, 8'hFF);

    // Back-to-back loads at the earliest accepted edge, model-checked
    for (int k = 0; k < 6; k++) begin
      pulse_load(extra_vals[k], k[0], extra_dps[k]);
      wait_idle("b2b", n);
      pulse_load(extra_vals[5 - k], ~k[0], extra_dps[k]);
      wait_idle("b2b2", n);
      sweep_model();
    end

    // Reset mid-conversion
    @(negedge clk);
    pulse_load(98_765, 1'b0, 2);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst_n         = 1'b1;
    current_digit = 3'd0;
    @(negedge clk);
    chk("rst_mid_seg0", 32'(segments), 32'(7'b1000000));
    sweep("rst_mid", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                      7'b1000000}, 8'hFF);
    chk("rst_mid_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
